mult_div_unit: RTL and testbench

- Iterative multiply/divide unit in the execute stage, alongside the combinational ALU.
- Takes rs/rt operands and the R-type funct code on the same decode path as the ALU.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO; owns the architectural HI/LO registers.
- Result is produced over multiple cycles; the controller stalls on busy, and MFHI/MFLO read hi/lo directly.

---
 rtl/mult_div_pkg.sv | 31 +++
 rtl/mult_div_sign_fix.sv | 64 ++++++
 rtl/mult_div_unit.sv | 195 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: R-type funct
// codes it recognises, controller states and the iteration count.
package mult_div_pkg;

    // Operand width the unit is built and verified for.
    localparam int WIDTH_DEF = 32;

    // One shift-add / shift-subtract iteration per operand bit.
    localparam int ITER = WIDTH_DEF;

    typedef enum logic [5:0] {
        FN_MTHI  = 6'b010001,
        FN_MTLO  = 6'b010011,
        FN_MULT  = 6'b011000,
        FN_MULTU = 6'b011001,
        FN_DIV   = 6'b011010,
        FN_DIVU  = 6'b011011
    } funct_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // True for the two divide flavours.
    function automatic logic fn_is_div(input funct_e fn);
        return (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_sign_fix.sv
// Final result shaping for the multiply/divide unit: applies the recorded
// operand signs to the unsigned magnitude result and applies the
// divide-by-zero and signed-overflow overrides. Purely combinational.
module mult_div_sign_fix
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  funct_e             op,
    input  logic [2*WIDTH-1:0] raw,
    input  logic               a_neg,
    input  logic               b_neg,
    input  logic [WIDTH-1:0]   a_raw,
    input  logic [WIDTH-1:0]   b_raw,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [2*WIDTH-1:0] neg_prod;
    logic [WIDTH-1:0]   neg_quot;
    logic [WIDTH-1:0]   neg_rem;
    logic [WIDTH-1:0]   min_neg;
    logic               b_zero;

    assign neg_prod = ~raw + 1'b1;
    assign neg_quot = ~raw[WIDTH-1:0] + 1'b1;
    assign neg_rem  = ~raw[2*WIDTH-1:WIDTH] + 1'b1;
    assign min_neg  = {1'b1, {(WIDTH-1){1'b0}}};
    assign b_zero   = (b_raw == '0);

    // Raw layout is {upper, lower}: product halves or {remainder, quotient}.
    always_comb begin
        hi = raw[2*WIDTH-1:WIDTH];
        lo = raw[WIDTH-1:0];
        case (op)
            FN_MULT: begin
                if (a_neg ^ b_neg) begin
                    {hi, lo} = neg_prod;
                end
            end
            FN_DIV: begin
                if (b_zero) begin
                    hi = a_raw;
                    lo = '1;
                end else if ((a_raw == min_neg) && (b_raw == '1)) begin
                    hi = '0;
                    lo = min_neg;
                end else begin
                    // Quotient truncates toward zero; remainder follows the dividend.
                    if (a_neg ^ b_neg) lo = neg_quot;
                    if (a_neg)         hi = neg_rem;
                end
            end
            FN_DIVU: begin
                if (b_zero) begin
                    hi = a_raw;
                    lo = '1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract, one bit
// per clock, followed by a sign-fix cycle. MTHI/MTLO write in one edge.
// Optional macro MULT_DIV_FAST_ZERO_EN: multiplies by zero and divides by
// zero skip the iteration phase and go straight to the sign-fix cycle.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(ITER + 1);

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]   opnd_reg, opnd_next;
    funct_e             op_reg, op_next;
    logic               a_neg_reg, a_neg_next;
    logic               b_neg_reg, b_neg_next;
    logic [WIDTH-1:0]   a_raw_reg, a_raw_next;
    logic [WIDTH-1:0]   b_raw_reg, b_raw_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               done_reg, done_next;

    // Operand decode at acceptance.
    funct_e           op_in;
    logic             in_signed;
    logic             in_mul;
    logic             a_neg_in, b_neg_in;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_in     = funct_e'(op);
    assign in_signed = (op_in == FN_MULT) || (op_in == FN_DIV);
    assign in_mul    = (op_in == FN_MULT) || (op_in == FN_MULTU);
    assign a_neg_in  = in_signed & a[WIDTH-1];
    assign b_neg_in  = in_signed & b[WIDTH-1];
    assign a_mag     = a_neg_in ? (~a + 1'b1) : a;
    assign b_mag     = b_neg_in ? (~b + 1'b1) : b;

    // One multiply iteration: conditionally add multiplicand, shift right.
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;

    assign mul_addend = acc_reg[0] ? opnd_reg : '0;
    assign mul_sum    = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign mul_step   = {mul_sum, acc_reg[WIDTH-1:1]};

    // One divide iteration: shift left, trial-subtract the divisor and keep
    // the difference only when it does not go negative.
    logic [WIDTH:0]     div_shifted;
    logic [WIDTH:0]     div_trial;
    logic               div_fits;
    logic [2*WIDTH-1:0] div_step;

    assign div_shifted = acc_reg[2*WIDTH-1:WIDTH-1];
    assign div_fits    = (div_shifted >= {1'b0, opnd_reg});
    assign div_trial   = div_shifted - {1'b0, opnd_reg};
    assign div_step    = div_fits ? {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1}
                                  : {acc_reg[2*WIDTH-2:0], 1'b0};

    logic [WIDTH-1:0] fix_hi, fix_lo;

    mult_div_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .op    (op_reg),
        .raw   (acc_reg),
        .a_neg (a_neg_reg),
        .b_neg (b_neg_reg),
        .a_raw (a_raw_reg),
        .b_raw (b_raw_reg),
        .hi    (fix_hi),
        .lo    (fix_lo)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            acc_reg   <= '0;
            opnd_reg  <= '0;
            op_reg    <= FN_MULT;
            a_neg_reg <= 1'b0;
            b_neg_reg <= 1'b0;
            a_raw_reg <= '0;
            b_raw_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            acc_reg   <= acc_next;
            opnd_reg  <= opnd_next;
            op_reg    <= op_next;
            a_neg_reg <= a_neg_next;
            b_neg_reg <= b_neg_next;
            a_raw_reg <= a_raw_next;
            b_raw_reg <= b_raw_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            done_reg  <= done_next;
        end
    end

    // Next-state and datapath control: accept, iterate, then fix and publish.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        acc_next   = acc_reg;
        opnd_next  = opnd_reg;
        op_next    = op_reg;
        a_neg_next = a_neg_reg;
        b_neg_next = b_neg_reg;
        a_raw_next = a_raw_reg;
        b_raw_next = b_raw_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    case (op_in)
                        FN_MTHI: hi_next = a;
                        FN_MTLO: lo_next = a;
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            op_next    = op_in;
                            a_neg_next = a_neg_in;
                            b_neg_next = b_neg_in;
                            a_raw_next = a;
                            b_raw_next = b;
                            count_next = '0;
                            state_next = ST_RUN;
                            if (in_mul) begin
                                opnd_next = a_mag;
                                acc_next  = {{WIDTH{1'b0}}, b_mag};
                            end else begin
                                opnd_next = b_mag;
                                acc_next  = {{WIDTH{1'b0}}, a_mag};
                            end
`ifdef MULT_DIV_FAST_ZERO_EN
                            // Zero product / divide-by-zero need no iterations;
                            // sign fix supplies the divide-by-zero result.
                            if (in_mul ? ((a == '0) || (b == '0)) : (b == '0)) begin
                                acc_next   = '0;
                                state_next = ST_FIX;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                count_next = count_reg + CNT_W'(1);
                acc_next   = fn_is_div(op_reg) ? div_step : mul_step;
                if (count_reg == CNT_W'(ITER - 1)) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                hi_next    = fix_hi;
                lo_next    = fix_lo;
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// busy/reset sequences and randomized operations against an arithmetic model.
module tb_mult_div_unit;

    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

`ifdef MULT_DIV_FAST_ZERO_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result from plain 64-bit arithmetic.
    function automatic void model(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sx, sy, p;
        logic [63:0] up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        h = 32'h0;
        l = 32'h0;
        case (o)
            OP_MULT: begin
                p = sx * sy;
                h = p[63:32];
                l = p[31:0];
            end
            OP_MULTU: begin
                up = {32'h0, x} * {32'h0, y};
                h = up[63:32];
                l = up[31:0];
            end
            OP_DIV: begin
                if (y == 32'h0) begin
                    h = x; l = 32'hFFFF_FFFF;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    h = 32'h0; l = 32'h8000_0000;
                end else begin
                    p = sx / sy;
                    l = p[31:0];
                    p = sx % sy;
                    h = p[31:0];
                end
            end
            OP_DIVU: begin
                if (y == 32'h0) begin
                    h = x; l = 32'hFFFF_FFFF;
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic int exp_lat(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
        bit fast;
        fast = ((o == OP_MULT || o == OP_MULTU) && (x == 0 || y == 0)) ||
               ((o == OP_DIV || o == OP_DIVU) && (y == 0));
        return (FAST_EN && fast) ? 1 : 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one multiply/divide, wait for done and check timing and result.
    task automatic run_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
        int cyc;
        bit stable;
        bit seen;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 6'($urandom); a = $urandom; b = $urandom;
        check("busy_after_start", busy, 1'b1);
        cyc = 0; stable = 1'b1; seen = 1'b0;
        while (cyc < 40 && !seen) begin
            if (hi !== mdl_hi || lo !== mdl_lo) stable = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        check("latency", seen ? cyc : 999, exp_lat(o, x, y));
        check("hilo_stable", stable, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("hi", hi, eh);
        check("lo", lo, el);
        $display("op=%b a=%h b=%h -> hi=%h lo=%h cycles=%0d", o, x, y, hi, lo, cyc);
        mdl_hi = eh;
        mdl_lo = el;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[12];
        logic [31:0] eh, el;
        logic [5:0]  rop;
        logic [31:0] rx, ry;
        int          cyc;
        bit          seen;

        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{OP_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
        vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
        vecs[6]  = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[7]  = '{OP_MULT,  32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[8]  = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[9]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[10] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[11] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};

        reset_n = 1'b0; start = 1'b0; op = 6'h0; a = 32'h0; b = 32'h0;
        mdl_hi = 32'h0; mdl_lo = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed table; consecutive ops also exercise start in the done cycle.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end

        // MTLO / MTHI write one register and leave the other alone.
        start = 1'b1; op = OP_MTLO; a = 32'h0000_1234;
        @(posedge clk); #1; start = 1'b0;
        check("mtlo_lo", lo, 32'h0000_1234);
        check("mtlo_hi", hi, mdl_hi);
        check("mtlo_done", done, 1'b0);
        check("mtlo_busy", busy, 1'b0);
        mdl_lo = 32'h0000_1234;
        $display("MTLO a=00001234 -> hi=%h lo=%h", hi, lo);
        start = 1'b1; op = OP_MTHI; a = 32'hCAFE_0001;
        @(posedge clk); #1; start = 1'b0;
        check("mthi_hi", hi, 32'hCAFE_0001);
        check("mthi_lo", lo, mdl_lo);
        mdl_hi = 32'hCAFE_0001;
        $display("MTHI a=cafe0001 -> hi=%h lo=%h", hi, lo);

        // Unknown funct code is ignored.
        start = 1'b1; op = 6'b100000; a = 32'h5555_5555; b = 32'h3;
        @(posedge clk); #1; start = 1'b0;
        check("badop_busy", busy, 1'b0);
        check("badop_hi", hi, mdl_hi);
        check("badop_lo", lo, mdl_lo);
        $display("op=100000 ignored -> busy=%b hi=%h lo=%h", busy, hi, lo);

        // MULT in flight; MTHI and MULTU issued while busy must be ignored.
        model(OP_MULT, 32'h0000_0007, 32'hFFFF_FFF7, eh, el);
        start = 1'b1; op = OP_MULT; a = 32'h0000_0007; b = 32'hFFFF_FFF7;
        @(posedge clk); #1;
        cyc = 0; seen = 1'b0;
        while (cyc < 40 && !seen) begin
            start = (cyc == 2 || cyc == 5);
            op = (cyc == 2) ? OP_MTHI : OP_MULTU;
            a = 32'h0000_DEAD; b = 32'h3;
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        check("busy_ign_latency", seen ? cyc : 999, 33);
        check("busy_ign_hi", hi, eh);
        check("busy_ign_lo", lo, el);
        check("busy_ign_busy", busy, 1'b0);
        $display("MULT with ignored MTHI/MULTU -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
        mdl_hi = eh; mdl_lo = el;

        // Reset in the middle of a DIV aborts it.
        start = 1'b1; op = OP_DIV; a = 32'h0000_0064; b = 32'h0000_0003;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        @(posedge clk); #1 reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        check("abort_no_done", seen, 1'b0);
        $display("DIV aborted by reset -> busy=%b hi=%h lo=%h", busy, hi, lo);
        mdl_hi = 32'h0; mdl_lo = 32'h0;

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: rop = OP_MULT;
                1: rop = OP_MULTU;
                2: rop = OP_DIV;
                default: rop = OP_DIVU;
            endcase
            rx = pick();
            ry = pick();
            model(rop, rx, ry, eh, el);
            run_op(rop, rx, ry, eh, el);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
